frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 Parameter FRAME_PIXELS, default 76800: pixels per complete 320x240 frame.
REQ-002 Parameter SPLIT_ADDR, default 32768: first pixel address stored in the high RAM.
REQ-003 pclk  in  1  camera pixel clock; the only clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 config_done  in  1  camera register configuration complete; level.
REQ-006 cam_vsync  in  1  camera VSYNC; high = vertical blanking.
REQ-007 cam_we, cam_addr, cam_data  in  1/17/16  pixel write strobe, pixel address and RGB565 data from the capture block.
REQ-008 freeze_sw, snap_btn  in  1/1  freeze-mode level; snapshot request, asynchronous level.
REQ-009 wren_lo, wren_hi  out  1/1  write enables for the low and high frame RAMs.
REQ-010 wraddr  out  16  RAM-local write address.
REQ-011 wrdata  out  16  registered write data.
REQ-012 wr_bank, disp_bank  out  1/1  buffer bank being written; bank holding the last complete frame.
REQ-013 frame_done  out  1  one-cycle pulse on acceptance of a complete frame.
REQ-014 frame_cnt  out  8  count of accepted frames; wraps 255->0.
REQ-015 err_short, err_ovf  out  1/1  sticky flags: short frame seen; write address >= FRAME_PIXELS seen.
REQ-016 busy  out  1  high in CAPTURE state.

Function
REQ-017 cam_vsync registered once; frame start = falling edge, frame end = rising edge of the registered copy.
REQ-018 States: IDLE, WAIT_SYNC, CAPTURE, HOLD.
REQ-019 IDLE -> WAIT_SYNC when config_done=1.
REQ-020 WAIT_SYNC -> CAPTURE on frame start; the pixel counter clears on the same cycle.
REQ-021 CAPTURE -> on frame end: frame evaluation, then WAIT_SYNC, or HOLD when freeze_sw=1 or when the frame was a snapshot.
REQ-022 HOLD -> WAIT_SYNC on snapshot request (armed single frame) or on freeze_sw=0; no writes in HOLD.
REQ-023 config_done=0 in any state -> IDLE next cycle; the current frame is discarded with no swap and no frame_done.
REQ-024 In CAPTURE, each cam_we=1 with cam_addr<FRAME_PIXELS produces one write, registered with 1-cycle latency.
REQ-025 Write routing: cam_addr<SPLIT_ADDR -> wren_lo=1, wraddr=cam_addr[15:0]; otherwise wren_hi=1, wraddr=cam_addr-SPLIT_ADDR truncated to 16 bits.
REQ-026 wren_lo and wren_hi are never high together; both are 0 outside CAPTURE.
REQ-027 cam_we with cam_addr>=FRAME_PIXELS: write suppressed, err_ovf set; the pixel counter does not increment.
REQ-028 A 17-bit pixel counter counts accepted writes and saturates at FRAME_PIXELS.
REQ-029 Frame evaluation, count==FRAME_PIXELS: disp_bank<=wr_bank, wr_bank<=~wr_bank, frame_done pulses, frame_cnt increments, all on the same cycle.
REQ-030 Frame evaluation, count<FRAME_PIXELS: no swap, no pulse, err_short set; the frame is overwritten by the next frame.
REQ-031 snap_btn: 2-flop synchronizer, then rising-edge detect; a request outside HOLD is ignored.
REQ-032 Frame start and frame end on the same registered sample are impossible; a cam_we coincident with frame end is still written.
REQ-033 err_short and err_ovf clear only on reset.

Reset
REQ-034 Reset values: state=IDLE, wr_bank=0, disp_bank=1, all enables, pulses, counters and flags 0, wraddr=0, wrdata=0.
REQ-035 Reset assertion mid-frame takes effect immediately (asynchronous); release is synchronized to pclk by the instantiating level.

Structure
REQ-036 Shared package cam_pkg holds: FRAME_PIXELS, SPLIT_ADDR, H_RES=320, V_RES=240, and the state encoding typedef.
REQ-037 One sub-module, sync_edge_det, provides the 2-flop synchronizer and rising-edge detector used for snap_btn.

Verification
REQ-038 Reset release, config_done=1, one full frame of addresses 0..76799 -> 76800 writes, 32768 on wren_lo, 44032 on wren_hi (last wraddr=44031), frame_done=1, wr_bank=1, disp_bank=0, frame_cnt=1.
REQ-039 Frame ending after 50000 writes -> err_short=1, no frame_done, banks unchanged; next full frame swaps normally.
REQ-040 cam_addr=76800 with cam_we=1 -> no enable asserted, err_ovf=1, pixel count unchanged.
REQ-041 config_done dropped at pixel 40000 -> enables low next cycle, state IDLE, no swap; re-assert -> capture resumes at the next frame start.
REQ-042 freeze_sw=1, then two snap_btn pulses spaced one frame apart -> exactly one frame accepted per pulse; HOLD in between with zero writes.
REQ-043 255 complete frames, then one more -> frame_cnt wraps to 0; disp_bank toggles on every accepted frame.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the camera frame capture path.
package cam_pkg;

    localparam int unsigned H_RES        = 320;
    localparam int unsigned V_RES        = 240;
    localparam int unsigned FRAME_PIXELS = H_RES * V_RES;
    localparam int unsigned SPLIT_ADDR   = 32768;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_HOLD      = 2'd3
    } cap_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous level input.
module sync_edge_det (
    input  logic pclk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       prev_q;
    logic       prev_d;

    // Shift the raw input through the synchronizer and keep one delayed copy.
    always_comb begin
        sync_d = {sync_q[0], async_in};
        prev_d = sync_q[1];
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: routes camera pixel writes into a split
// low/high frame RAM pair, double-buffers complete frames and supports
// a freeze / single-snapshot mode.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | camera not configured; no writes
// WAIT_SYNC | waiting for VSYNC falling edge (start of next frame)
// CAPTURE   | writing pixels; frame evaluated on VSYNC rising edge
// HOLD      | frozen display; no writes until snapshot or unfreeze
module frame_capture_ctrl #(
    parameter int unsigned FRAME_PIXELS = cam_pkg::FRAME_PIXELS,
    parameter int unsigned SPLIT_ADDR   = cam_pkg::SPLIT_ADDR
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        config_done,
    input  logic        cam_vsync,
    input  logic        cam_we,
    input  logic [16:0] cam_addr,
    input  logic [15:0] cam_data,
    input  logic        freeze_sw,
    input  logic        snap_btn,
    output logic        wren_lo,
    output logic        wren_hi,
    output logic [15:0] wraddr,
    output logic [15:0] wrdata,
    output logic        wr_bank,
    output logic        disp_bank,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        err_short,
    output logic        err_ovf,
    output logic        busy
);

    import cam_pkg::*;

    localparam logic [16:0] FRAME_LIM = 17'(FRAME_PIXELS);
    localparam logic [16:0] SPLIT_LIM = 17'(SPLIT_ADDR);

    cap_state_t  state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic [16:0] pix_cnt_q, pix_cnt_d;
    logic        wr_bank_q, wr_bank_d;
    logic        disp_bank_q, disp_bank_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        err_short_q, err_short_d;
    logic        err_ovf_q, err_ovf_d;
    logic        snap_armed_q, snap_armed_d;
    logic        wren_lo_q, wren_lo_d;
    logic        wren_hi_q, wren_hi_d;
    logic [15:0] wraddr_q, wraddr_d;
    logic [15:0] wrdata_q, wrdata_d;

    logic        snap_rise;
    logic        frame_start;
    logic        frame_end;
    logic        in_capture;
    logic        pix_valid;
    logic        pix_lo;
    logic        pix_wr;
    logic        pix_ovf;
    logic [16:0] pix_cnt_inc;
    logic        frame_full;
    logic [15:0] addr_hi_off;

    sync_edge_det u_snap_sync (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .async_in (snap_btn),
        .rise     (snap_rise)
    );

    // VSYNC edge detection on the once-registered copy and pixel qualification.
    always_comb begin
        vsync_d      = cam_vsync;
        vsync_prev_d = vsync_q;
        frame_start  = vsync_prev_q & ~vsync_q;
        frame_end    = ~vsync_prev_q & vsync_q;
        in_capture   = (state_q == ST_CAPTURE);
        pix_valid    = (cam_addr < FRAME_LIM);
        pix_lo       = (cam_addr < SPLIT_LIM);
        pix_wr       = in_capture & config_done & cam_we & pix_valid;
        pix_ovf      = in_capture & config_done & cam_we & ~pix_valid;
        addr_hi_off  = 16'(cam_addr - SPLIT_LIM);
        // The write that coincides with frame end still counts toward the frame.
        if (pix_wr && (pix_cnt_q < FRAME_LIM)) begin
            pix_cnt_inc = pix_cnt_q + 17'd1;
        end else begin
            pix_cnt_inc = pix_cnt_q;
        end
        frame_full = (pix_cnt_inc == FRAME_LIM);
    end

    // Write routing to the low/high RAM with one cycle of registration.
    always_comb begin
        wren_lo_d = pix_wr & pix_lo;
        wren_hi_d = pix_wr & ~pix_lo;
        wraddr_d  = wraddr_q;
        wrdata_d  = wrdata_q;
        if (pix_wr) begin
            wraddr_d = pix_lo ? cam_addr[15:0] : addr_hi_off;
            wrdata_d = cam_data;
        end
    end

    // Capture sequencing, frame evaluation and bank swap.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        wr_bank_d    = wr_bank_q;
        disp_bank_d  = disp_bank_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_short_d  = err_short_q;
        err_ovf_d    = err_ovf_q | pix_ovf;
        snap_armed_d = snap_armed_q;

        if (!config_done) begin
            // Losing configuration abandons any frame in flight.
            state_d      = ST_IDLE;
            snap_armed_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (frame_start) begin
                        state_d   = ST_CAPTURE;
                        pix_cnt_d = 17'd0;
                    end
                end
                ST_CAPTURE: begin
                    pix_cnt_d = pix_cnt_inc;
                    if (frame_end) begin
                        if (frame_full) begin
                            disp_bank_d  = wr_bank_q;
                            wr_bank_d    = ~wr_bank_q;
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                        end else begin
                            err_short_d = 1'b1;
                        end
                        // A snapshot frame always lands in HOLD, even if short.
                        state_d      = (freeze_sw || snap_armed_q) ? ST_HOLD : ST_WAIT_SYNC;
                        snap_armed_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (snap_rise) begin
                        state_d      = ST_WAIT_SYNC;
                        snap_armed_d = 1'b1;
                    end else if (!freeze_sw) begin
                        state_d = ST_WAIT_SYNC;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, status and write-port registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            pix_cnt_q    <= 17'd0;
            wr_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b1;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            err_short_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            snap_armed_q <= 1'b0;
            wren_lo_q    <= 1'b0;
            wren_hi_q    <= 1'b0;
            wraddr_q     <= 16'd0;
            wrdata_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            pix_cnt_q    <= pix_cnt_d;
            wr_bank_q    <= wr_bank_d;
            disp_bank_q  <= disp_bank_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_short_q  <= err_short_d;
            err_ovf_q    <= err_ovf_d;
            snap_armed_q <= snap_armed_d;
            wren_lo_q    <= wren_lo_d;
            wren_hi_q    <= wren_hi_d;
            wraddr_q     <= wraddr_d;
            wrdata_q     <= wrdata_d;
        end
    end

    assign wren_lo    = wren_lo_q;
    assign wren_hi    = wren_hi_q;
    assign wraddr     = wraddr_q;
    assign wrdata     = wrdata_q;
    assign wr_bank    = wr_bank_q;
    assign disp_bank  = disp_bank_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_short  = err_short_q;
    assign err_ovf    = err_ovf_q;
    assign busy       = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl using a reduced frame size so that the
// long multi-frame scenarios stay short.
module tb_frame_capture_ctrl;

    localparam int FP = 48;
    localparam int SP = 32;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        config_done = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_we = 1'b0;
    logic [16:0] cam_addr = '0;
    logic [15:0] cam_data = '0;
    logic        freeze_sw = 1'b0;
    logic        snap_btn = 1'b0;
    logic        wren_lo, wren_hi;
    logic [15:0] wraddr, wrdata;
    logic        wr_bank, disp_bank, frame_done;
    logic [7:0]  frame_cnt;
    logic        err_short, err_ovf, busy;

    frame_capture_ctrl #(.FRAME_PIXELS(FP), .SPLIT_ADDR(SP)) dut (
        .pclk(pclk), .rst_n(rst_n), .config_done(config_done),
        .cam_vsync(cam_vsync), .cam_we(cam_we), .cam_addr(cam_addr),
        .cam_data(cam_data), .freeze_sw(freeze_sw), .snap_btn(snap_btn),
        .wren_lo(wren_lo), .wren_hi(wren_hi), .wraddr(wraddr), .wrdata(wrdata),
        .wr_bank(wr_bank), .disp_bank(disp_bank), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_short(err_short), .err_ovf(err_ovf),
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard: {wren_lo, wren_hi, wraddr, wrdata}
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    bit          mon_en = 1'b0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          last_hi_addr = -1;
    int          done_seen = 0;

    logic        exp_wr_bank = 1'b0;
    logic        exp_disp = 1'b1;
    logic [7:0]  exp_cnt = 8'd0;
    int          exp_done = 0;

    always @(negedge pclk) begin
        if (mon_en) begin
            chk("wren_exclusive", 64'(wren_lo & wren_hi), 64'd0);
            if (wren_lo || wren_hi) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'({wren_lo, wren_hi, wraddr, wrdata}), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", 64'({wren_lo, wren_hi, wraddr, wrdata}), 64'(mon_e));
                end
                if (wren_lo) lo_cnt++;
                if (wren_hi) begin
                    hi_cnt++;
                    last_hi_addr = int'(wraddr);
                end
            end
            if (frame_done) done_seen++;
        end
    end

    task automatic push_wr(input int addr, input logic [15:0] data);
        logic        lo;
        logic [15:0] la;
        lo = (addr < SP);
        la = lo ? 16'(addr) : 16'(addr - SP);
        exp_q.push_back({lo, ~lo, la, data});
    endtask

    task automatic accept();
        exp_disp    = exp_wr_bank;
        exp_wr_bank = ~exp_wr_bank;
        exp_cnt     = exp_cnt + 8'd1;
        exp_done++;
    endtask

    task automatic check_model(input string pfx);
        chk({pfx, "_wr_bank"}, 64'(wr_bank), 64'(exp_wr_bank));
        chk({pfx, "_disp_bank"}, 64'(disp_bank), 64'(exp_disp));
        chk({pfx, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
        chk({pfx, "_done_pulses"}, 64'(done_seen), 64'(exp_done));
    endtask

    // One camera frame: vsync low, n_pix sequential pixels, vsync high.
    // ovf_pos inserts an out-of-range pixel; drop_pos removes config_done.
    task automatic drive_frame(input int n_pix, input bit exp_wr, input int ovf_pos, input int drop_pos);
        bit live;
        logic [15:0] d;
        live = exp_wr;
        @(negedge pclk);
        cam_vsync = 1'b0;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < n_pix; i++) begin
            if (drop_pos >= 0 && i == drop_pos) begin
                config_done = 1'b0;
                live = 1'b0;
            end
            if (drop_pos >= 0 && i == drop_pos + 2) chk("busy_after_drop", 64'(busy), 64'd0);
            if (drop_pos >= 0 && i == drop_pos + 5) config_done = 1'b1;
            if (!exp_wr && i == n_pix / 2) chk("busy_in_hold", 64'(busy), 64'd0);
            if (i == ovf_pos) begin
                cam_we = 1'b1;
                cam_addr = 17'(FP);
                cam_data = 16'($urandom);
                @(negedge pclk);
            end
            d = 16'($urandom);
            cam_we = 1'b1;
            cam_addr = 17'(i);
            cam_data = d;
            if (live) push_wr(i, d);
            @(negedge pclk);
        end
        cam_we = 1'b0;
        cam_vsync = 1'b1;
        repeat (6) @(negedge pclk);
    endtask

    task automatic snap_pulse();
        snap_btn = 1'b1;
        repeat (4) @(negedge pclk);
        snap_btn = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        chk("rst_wren_lo", 64'(wren_lo), 64'd0);
        chk("rst_wren_hi", 64'(wren_hi), 64'd0);
        chk("rst_wraddr", 64'(wraddr), 64'd0);
        chk("rst_wrdata", 64'(wrdata), 64'd0);
        chk("rst_wr_bank", 64'(wr_bank), 64'd0);
        chk("rst_disp_bank", 64'(disp_bank), 64'd1);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err_short", 64'(err_short), 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge pclk);
        config_done = 1'b1;
        repeat (3) @(negedge pclk);

        // full frame
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("full1");
        chk("full1_lo_writes", 64'(lo_cnt), 64'(SP));
        chk("full1_hi_writes", 64'(hi_cnt), 64'(FP - SP));
        chk("full1_last_hi_addr", 64'(last_hi_addr), 64'(FP - SP - 1));

        // short frame, then a normal one
        drive_frame(30, 1'b1, -1, -1);
        check_model("short");
        chk("short_err_short", 64'(err_short), 64'd1);
        chk("short_err_ovf", 64'(err_ovf), 64'd0);
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("after_short");

        // overflow pixel must not count toward the frame
        drive_frame(FP - 1, 1'b1, 10, -1);
        chk("ovf_err_ovf", 64'(err_ovf), 64'd1);
        check_model("ovf");

        // config_done dropped mid-frame, restored before frame end
        drive_frame(FP, 1'b1, -1, 25);
        check_model("drop");
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("resume");

        // freeze with two single-frame snapshots
        freeze_sw = 1'b1;
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("freeze1");
        drive_frame(FP, 1'b0, -1, -1);
        check_model("hold1");
        snap_pulse();
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("snap1");
        drive_frame(FP, 1'b0, -1, -1);
        check_model("hold2");
        snap_pulse();
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("snap2");
        drive_frame(FP, 1'b0, -1, -1);
        check_model("hold3");
        freeze_sw = 1'b0;
        repeat (3) @(negedge pclk);

        // run up to 255 accepted frames, then wrap
        while (exp_cnt != 8'd255) begin
            drive_frame(FP, 1'b1, -1, -1);
            accept();
            chk("disp_toggle", 64'(disp_bank), 64'(exp_disp));
        end
        check_model("cnt255");
        drive_frame(FP, 1'b1, -1, -1);
        accept();
        check_model("wrap");
        chk("wrap_frame_cnt_zero", 64'(frame_cnt), 64'd0);
        chk("sticky_err_short", 64'(err_short), 64'd1);
        chk("sticky_err_ovf", 64'(err_ovf), 64'd1);

        repeat (3) @(negedge pclk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
